// File: rtl/note_pkg.sv
// Shared note-word layout, constants and sequencer state type.
package note_pkg;

    localparam int unsigned END_BIT   = 31;
    localparam int unsigned PITCH_MSB = 23;
    localparam int unsigned PITCH_LSB = 16;
    localparam int unsigned DUR_MSB   = 15;
    localparam int unsigned DUR_LSB   = 0;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned PITCH_W   = PITCH_MSB - PITCH_LSB + 1;
    localparam int unsigned FIELD_W   = DUR_MSB - DUR_LSB + 1;

    localparam logic [PITCH_W-1:0] PITCH_REST  = 8'd0;
    localparam logic [ADDR_W-1:0]  WORD_STRIDE = 32'd4;

    typedef struct packed {
        logic               end_flag;
        logic [6:0]         rsvd;
        logic [PITCH_W-1:0] pitch;
        logic [FIELD_W-1:0] dur;
    } note_word_t;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} seq_state_t;

endpackage

// File: rtl/dur_counter.sv
// Loadable tick down-counter; expire flags the tick that ends the count.
module dur_counter
    import note_pkg::*;
#(
    parameter int unsigned DUR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [DUR_W-1:0] cnt;

    assign expire = tick && (cnt == DUR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - DUR_W'(1);
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Walks note words from memory and plays each as pitch/gate for its tick count.
// Optional build macro SEQ_LOOP_EN: END word rewinds to BASE_ADDR instead of finishing.
module note_sequencer
    import note_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DUR_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        tick,
    output logic [31:0] mem_addr,
    input  logic [31:0] note,
    input  logic        too_high,
    output logic [7:0]  pitch,
    output logic        gate,
    output logic        note_start,
    output logic        busy,
    output logic        done,
    output logic        err
);

    seq_state_t  state, state_nxt;
    note_word_t  word;
    logic [31:0] addr_nxt;
    logic [7:0]  pitch_nxt;
    logic        gate_nxt, note_start_nxt, busy_nxt, done_nxt, err_nxt;
    logic        cnt_load, cnt_tick, expire;
    logic        unused_rsvd;

    assign word        = note_word_t'(note);
    assign unused_rsvd = ^word.rsvd;

    // Counter controls kept outside the FSM block so expire never feeds back into them.
    assign cnt_load = (state == FETCH) && !stop && !too_high && !word.end_flag
                      && (word.dur != '0);
    assign cnt_tick = (state == PLAY) && tick && !stop;

    dur_counter #(.DUR_W(DUR_W)) u_dur (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (DUR_W'(word.dur)),
        .tick     (cnt_tick),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_addr   <= BASE_ADDR;
            pitch      <= PITCH_REST;
            gate       <= 1'b0;
            note_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_addr   <= addr_nxt;
            pitch      <= pitch_nxt;
            gate       <= gate_nxt;
            note_start <= note_start_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        addr_nxt       = mem_addr;
        pitch_nxt      = pitch;
        gate_nxt       = gate;
        note_start_nxt = 1'b0;
        done_nxt       = done;
        err_nxt        = err;

        if (stop) begin
            state_nxt = IDLE;
            gate_nxt  = 1'b0;
            pitch_nxt = PITCH_REST;
        end else begin
            case (state)
                IDLE, DONE: begin
                    gate_nxt = 1'b0;
                    if (start) begin
                        addr_nxt  = BASE_ADDR;
                        done_nxt  = 1'b0;
                        err_nxt   = 1'b0;
                        state_nxt = FETCH;
                    end
                end
                FETCH: begin
                    gate_nxt = 1'b0;
                    if (too_high) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else if (word.end_flag) begin
`ifdef SEQ_LOOP_EN
                        if (mem_addr != BASE_ADDR) begin
                            addr_nxt = BASE_ADDR;
                        end else begin
                            done_nxt  = 1'b1;
                            state_nxt = DONE;
                        end
`else
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
`endif
                    end else if (word.dur == '0) begin
                        addr_nxt = mem_addr + WORD_STRIDE;
                    end else begin
                        pitch_nxt      = word.pitch;
                        gate_nxt       = (word.pitch != PITCH_REST);
                        note_start_nxt = 1'b1;
                        state_nxt      = PLAY;
                    end
                end
                PLAY: begin
                    if (expire) begin
                        addr_nxt  = mem_addr + WORD_STRIDE;
                        gate_nxt  = 1'b0;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt == FETCH) || (state_nxt == PLAY);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues expected notes/endings, monitor checks them.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, tick;
    logic [31:0] mem_addr, note;
    logic        too_high;
    logic [7:0]  pitch;
    logic        gate, note_start, busy, done, err;

    logic [31:0] mem [0:4095];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  pitch;
        logic        gate;
        logic [31:0] addr;
        int          dur;
    } note_exp_t;

    typedef struct {
        logic        done;
        logic        err;
        logic        gate;
        logic [7:0]  pitch;
        logic [31:0] addr;
        bit          chk_addr;
    } end_exp_t;

    note_exp_t note_q[$];
    end_exp_t  end_q[$];

    int  n_starts = 0;
    int  last_gap = -1;
    bit  tick_en  = 0;
    int  tick_per = 10;

    localparam logic [31:0] END_W = 32'h8000_0000;

    always #5 clk = ~clk;

    assign too_high = (mem_addr >= 32'h0000_4000);
    assign note     = too_high ? 32'h0 : mem[mem_addr[13:2]];

    note_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .mem_addr   (mem_addr),
        .note       (note),
        .too_high   (too_high),
        .pitch      (pitch),
        .gate       (gate),
        .note_start (note_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [31:0] nw(input logic [7:0] p, input logic [15:0] d);
        return {1'b0, 7'd0, p, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic tick_off();
        tick_en = 0;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    endtask

    task automatic push_note(input logic [7:0] p, input logic g, input logic [31:0] a, input int d);
        note_exp_t e;
        e.pitch = p; e.gate = g; e.addr = a; e.dur = d;
        note_q.push_back(e);
    endtask

    task automatic push_end(input logic dn, input logic er, input logic [7:0] p,
                            input logic [31:0] a, input bit ca);
        end_exp_t e;
        e.done = dn; e.err = er; e.gate = 1'b0; e.pitch = p; e.addr = a; e.chk_addr = ca;
        end_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk({name, "_timeout"}, 32'(busy), 32'h0);
        cyc(2);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_notes_left"}, 32'(note_q.size()), 32'h0);
        chk({name, "_ends_left"},  32'(end_q.size()),  32'h0);
        note_q.delete();
        end_q.delete();
    endtask

    // Free-running beat generator: one-cycle tick every tick_per cycles.
    initial begin
        int ctr = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                if (ctr >= tick_per - 1) begin
                    tick = 1'b1;
                    ctr  = 0;
                end else begin
                    tick = 1'b0;
                    ctr++;
                end
            end else begin
                ctr = 0;
            end
        end
    end

    // Monitor: pops expectations on note_start and on busy falling; tracks ticks per note and gate gaps.
    initial begin
        bit        playing = 0;
        bit        prev_busy = 0;
        bit        prev_gate = 0;
        logic [31:0] play_addr = '0;
        int        play_dur = 0;
        int        tick_cnt = 0;
        int        gap_cnt = 0;
        note_exp_t ne;
        end_exp_t  ee;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                playing = 0; prev_busy = 0; prev_gate = 0; gap_cnt = 0;
            end else begin
                if (playing) begin
                    if (!busy || mem_addr != play_addr) begin
                        playing = 0;
                        if (busy && play_dur != 0) chk("note_ticks", 32'(tick_cnt), 32'(play_dur));
                    end else if (tick) begin
                        tick_cnt++;
                    end
                end
                if (note_start) begin
                    n_starts++;
                    play_dur = 0;
                    if (note_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_note: pitch %0d at addr %0h, none expected", pitch, mem_addr);
                    end else begin
                        ne = note_q.pop_front();
                        chk("note_pitch", 32'(pitch), 32'(ne.pitch));
                        chk("note_gate",  32'(gate),  32'(ne.gate));
                        chk("note_addr",  mem_addr,   ne.addr);
                        play_dur = ne.dur;
                    end
                    playing   = 1;
                    play_addr = mem_addr;
                    tick_cnt  = tick ? 1 : 0;
                end
                if (prev_busy && !busy) begin
                    if (end_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_end: done %0b err %0b, none expected", done, err);
                    end else begin
                        ee = end_q.pop_front();
                        chk("end_done",  32'(done),  32'(ee.done));
                        chk("end_err",   32'(err),   32'(ee.err));
                        chk("end_gate",  32'(gate),  32'(ee.gate));
                        chk("end_pitch", 32'(pitch), 32'(ee.pitch));
                        if (ee.chk_addr) chk("end_addr", mem_addr, ee.addr);
                    end
                end
                if (!gate) begin
                    gap_cnt++;
                end else begin
                    if (!prev_gate) last_gap = gap_cnt;
                    gap_cnt = 0;
                end
                prev_busy = busy;
                prev_gate = gate;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        chk("rst_addr",       mem_addr,           32'h0);
        chk("rst_pitch",      32'(pitch),         32'h0);
        chk("rst_gate",       32'(gate),          32'h0);
        chk("rst_note_start", 32'(note_start),    32'h0);
        chk("rst_busy",       32'(busy),          32'h0);
        chk("rst_done",       32'(done),          32'h0);
        chk("rst_err",        32'(err),           32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(2);

`ifndef SEQ_LOOP_EN
        // Single note then END.
        clear_mem();
        mem[0] = nw(8'd60, 16'd2);
        mem[1] = END_W;
        push_note(8'd60, 1'b1, 32'h0, 2);
        push_end(1'b1, 1'b0, 8'd60, 32'h4, 1);
        tick_per = 10; tick_en = 1;
        pulse_start();
        wait_idle("t1", 200);
        tick_off();
        chk_drained("t1");

        // Back-to-back notes: one-cycle gate gap.
        clear_mem();
        mem[0] = nw(8'd62, 16'd1);
        mem[1] = nw(8'd64, 16'd1);
        mem[2] = END_W;
        push_note(8'd62, 1'b1, 32'h0, 1);
        push_note(8'd64, 1'b1, 32'h4, 1);
        push_end(1'b1, 1'b0, 8'd64, 32'h8, 1);
        n0 = n_starts; last_gap = -1;
        tick_per = 3; tick_en = 1;
        pulse_start();
        wait_idle("t2", 200);
        tick_off();
        chk("t2_note_starts", 32'(n_starts - n0), 32'd2);
        chk("t2_gate_gap",    32'(last_gap),      32'd1);
        chk_drained("t2");

        // Rest: pitch 0, no gate, still a note_start.
        clear_mem();
        mem[0] = nw(8'd0, 16'd3);
        mem[1] = END_W;
        push_note(8'd0, 1'b0, 32'h0, 3);
        push_end(1'b1, 1'b0, 8'd0, 32'h4, 1);
        n0 = n_starts;
        tick_per = 4; tick_en = 1;
        pulse_start();
        wait_idle("t3", 200);
        tick_off();
        chk("t3_note_starts", 32'(n_starts - n0), 32'd1);
        chk_drained("t3");

        // Zero-duration word is skipped silently.
        clear_mem();
        mem[0] = nw(8'd65, 16'd0);
        mem[1] = nw(8'd67, 16'd1);
        mem[2] = END_W;
        push_note(8'd67, 1'b1, 32'h4, 1);
        push_end(1'b1, 1'b0, 8'd67, 32'h8, 1);
        n0 = n_starts;
        tick_per = 2; tick_en = 1;
        pulse_start();
        wait_idle("t4", 200);
        tick_off();
        chk("t4_note_starts", 32'(n_starts - n0), 32'd1);
        chk_drained("t4");
`endif

        // Run off the end of memory into too_high.
        for (int i = 0; i < 4096; i++) begin
            mem[i] = nw(8'd70, 16'd1);
            push_note(8'd70, 1'b1, 32'(i * 4), 1);
        end
        push_end(1'b0, 1'b1, 8'd70, 32'h4000, 1);
        tick_per = 1; tick_en = 1;
        pulse_start();
        wait_idle("t5", 20000);
        tick_off();
        chk_drained("t5");
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
        chk("t5_err_after_stop",   32'(err),   32'h1);
        chk("t5_done_after_stop",  32'(done),  32'h0);
        chk("t5_pitch_after_stop", 32'(pitch), 32'h0);

        // Stop and tick together mid-note; start mid-note is ignored.
        clear_mem();
        mem[0] = nw(8'd60, 16'd5);
        mem[1] = END_W;
        push_note(8'd60, 1'b1, 32'h0, 0);
        push_end(1'b0, 1'b0, 8'd0, 32'h0, 1);
        pulse_start();
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (gate) begin seen = 1; break; end
            end
            if (!seen) chk("t6_gate_timeout", 32'(gate), 32'h1);
        end
        cyc(1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        pulse_start();
        cyc(2);
        chk("t6_still_playing", 32'(gate), 32'h1);
        stop = 1'b1; tick = 1'b1;
        cyc(1);
        stop = 1'b0; tick = 1'b0;
        cyc(2);
        chk("t6_busy",  32'(busy),  32'h0);
        chk("t6_gate",  32'(gate),  32'h0);
        chk("t6_pitch", 32'(pitch), 32'h0);
        chk("t6_addr",  mem_addr,   32'h0);
        chk_drained("t6");

`ifdef SEQ_LOOP_EN
        // Looping song rewinds on END and never sets done.
        clear_mem();
        mem[0] = nw(8'd60, 16'd1);
        mem[1] = END_W;
        for (int i = 0; i < 3; i++) push_note(8'd60, 1'b1, 32'h0, 1);
        push_end(1'b0, 1'b0, 8'd0, 32'h0, 0);
        n0 = n_starts;
        tick_per = 1; tick_en = 1;
        pulse_start();
        begin
            bit seen = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (n_starts - n0 >= 3) begin seen = 1; break; end
            end
            if (!seen) chk("loop_timeout", 32'(n_starts - n0), 32'd3);
        end
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        tick_off();
        cyc(2);
        chk("loop_done", 32'(done), 32'h0);
        chk("loop_busy", 32'(busy), 32'h0);
        chk_drained("loop");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
